// File: rtl/dispatch_pkg.sv
// Shared constants for the dispatch arbiter slice.
// Entry layout, FSM encodings and a pointer-width helper.
package dispatch_pkg;

  localparam int VALID_BIT = 1;
  localparam int OVERHEAD  = VALID_BIT;

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans requests starting at ptr, grants the first one found.
module rr_arbiter
  import dispatch_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] sel;

  // Rotate from ptr, take the first asserted request
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      sel = sum[PW-1:0];
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// Dispatch table front end: N-way write arbiter,
// single read port with write forwarding, table init.
module dispatch_arbiter
  import dispatch_pkg::*;
#(
  parameter int CORE        = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8,
  parameter int NUM_REQ     = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             wr_req,
  input  logic [NUM_REQ*INDEX_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data,
  input  logic [NUM_REQ-1:0]             wr_valid,
  output logic [NUM_REQ-1:0]             wr_gnt,
  input  logic                           rd_req,
  input  logic [INDEX_WIDTH-1:0]         rd_addr,
  output logic                           rd_ack,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_entry_valid,
  output logic                           busy,
  output logic                           ram_read,
  output logic [INDEX_WIDTH-1:0]         ram_read_addr,
  input  logic [DATA_WIDTH:0]            ram_read_data,
  output logic                           ram_write,
  output logic [INDEX_WIDTH-1:0]         ram_write_addr,
  output logic [DATA_WIDTH:0]            ram_write_data,
  input  logic                           report
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam int EW = DATA_WIDTH + OVERHEAD;
  localparam logic [INDEX_WIDTH-1:0] LAST = '1;

  logic [0:0]             state;
  logic [INDEX_WIDTH-1:0] init_addr;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          ptr_nxt;
  logic                   run;
  logic [NUM_REQ-1:0]     arb_req;
  logic                   any_gnt;
  logic [INDEX_WIDTH-1:0] sel_addr;
  logic [EW-1:0]          sel_data;
  logic                   wq_vld;
  logic [INDEX_WIDTH-1:0] wq_addr;
  logic [EW-1:0]          wq_data;
  logic                   fwd_hit;
  logic [EW-1:0]          fwd_data;
  logic [EW-1:0]          rd_word;
  logic [31:0]            cycles;

  assign run     = reset && (state == RUN);
  assign busy    = !run;
  assign arb_req = run ? wr_req : '0;
  assign any_gnt = |wr_gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (arb_req),
    .ptr (ptr),
    .gnt (wr_gnt)
  );

  // Pick the granted requester's operands and next pointer
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    ptr_nxt  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        sel_addr = wr_addr[i*INDEX_WIDTH +: INDEX_WIDTH];
        sel_data = {wr_valid[i],
                    wr_data[i*DATA_WIDTH +: DATA_WIDTH]};
        ptr_nxt  = (i == NUM_REQ-1) ? '0 : PW'(i+1);
      end
    end
  end

  // RAM write port: init sweep, else the write stage
  always_comb begin
    ram_write      = 1'b0;
    ram_write_addr = '0;
    ram_write_data = '0;
    if (reset) begin
      if (state == INIT) begin
        ram_write      = 1'b1;
        ram_write_addr = init_addr;
      end else if (wq_vld) begin
        ram_write      = 1'b1;
        ram_write_addr = wq_addr;
        ram_write_data = wq_data;
      end
    end
  end

  assign ram_read      = run && rd_req;
  assign ram_read_addr = rd_addr;

  assign rd_word        = fwd_hit ? fwd_data : ram_read_data;
  assign rd_data        = rd_ack ? rd_word[DATA_WIDTH-1:0] : '0;
  assign rd_entry_valid = rd_ack && rd_word[DATA_WIDTH];

  // INIT sweeps every address once, then RUN
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= INIT;
      init_addr <= '0;
    end else if (state == INIT) begin
      init_addr <= init_addr + 1'b1;
      if (init_addr == LAST)
        state <= RUN;
    end
  end

  // Round-robin pointer and registered write stage
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr     <= '0;
      wq_vld  <= 1'b0;
      wq_addr <= '0;
      wq_data <= '0;
    end else begin
      ptr    <= ptr_nxt;
      wq_vld <= any_gnt;
      if (any_gnt) begin
        wq_addr <= sel_addr;
        wq_data <= sel_data;
      end
    end
  end

  // Read ack, plus capture of a same-cycle write for forwarding
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ack   <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      rd_ack   <= ram_read;
      fwd_hit  <= ram_read && ram_write &&
                  (ram_write_addr == rd_addr);
      fwd_data <= ram_write_data;
    end
  end

  // Free-running cycle counter
  always_ff @(posedge clock) begin
    if (!reset)
      cycles <= '0;
    else
      cycles <= cycles + 32'd1;
  end

`ifndef SYNTHESIS
  // Debug trace of arbiter and RAM port activity
  always_ff @(posedge clock) begin
    if (report)
      $display("core%0d cyc=%0d st=%s ptr=%0d gnt=%b rd=%b@%h wr=%b@%h:%h",
               CORE, cycles,
               (state == RUN) ? "RUN" : "INIT",
               ptr, wr_gnt,
               ram_read, ram_read_addr,
               ram_write, ram_write_addr, ram_write_data);
  end
`endif

endmodule
